// File: rtl/fc_sequencer.sv
// fc_sequencer: steps one inference through three chained FC layers,
// pulsing each layer's reset, enabling it, and waiting for its finished
// flag. A per-layer RUN-cycle budget turns a hung layer into a sticky error.
module fc_sequencer #(
   parameter int unsigned L0_IN   = 400,
   parameter int unsigned L0_OUT  = 120,
   parameter int unsigned L1_OUT  = 84,
   parameter int unsigned L2_OUT  = 10,
   parameter int unsigned TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  layer_finished,
   output logic [2:0]  layer_enable,
   output logic [2:0]  layer_reset,
   output logic [15:0] weight_base,
   output logic [15:0] bias_base,
   output logic [1:0]  layer_idx,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [31:0] cycle_count
);

   // Parameter memory layout: all weights of layer k precede layer k+1's.
   localparam longint unsigned TOTAL_WORDS =
      longint'(L0_IN)  * longint'(L0_OUT) +
      longint'(L0_OUT) * longint'(L1_OUT) +
      longint'(L1_OUT) * longint'(L2_OUT) +
      longint'(L0_OUT) + longint'(L1_OUT) + longint'(L2_OUT);

   localparam logic [15:0] W_BASE1 = 16'(L0_IN * L0_OUT);
   localparam logic [15:0] W_BASE2 = 16'(L0_IN * L0_OUT + L0_OUT * L1_OUT);
   localparam logic [15:0] B_BASE1 = 16'(L0_OUT);
   localparam logic [15:0] B_BASE2 = 16'(L0_OUT + L1_OUT);
   localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

   generate
      if (TOTAL_WORDS > 64'd65536 || TIMEOUT == 0) begin : g_cfg_check
         $error("fc_sequencer: parameter memory exceeds 65536 words or TIMEOUT is zero");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE, LAUNCH, RUN, NEXT, DONE, ERROR
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  idx_q, idx_d;
   logic [31:0] tmo_q, tmo_d;
   logic        error_q, error_d;
   logic [31:0] cycle_q, cycle_d;
   logic [2:0]  onehot;
   logic        fin_act;

   assign onehot  = 3'b001 << idx_q;
   assign fin_act = |(layer_finished & onehot);

   // State and bookkeeping registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         idx_q   <= '0;
         tmo_q   <= '0;
         error_q <= 1'b0;
         cycle_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         tmo_q   <= tmo_d;
         error_q <= error_d;
         cycle_q <= cycle_d;
      end
   end

   // Next-state logic and per-state layer controls.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      tmo_d        = tmo_q;
      error_d      = error_q;
      cycle_d      = cycle_q;
      layer_enable = '0;
      layer_reset  = '0;
      busy         = 1'b0;
      done         = 1'b0;
      case (state_q)
         IDLE: begin
            idx_d = '0;
            if (start) begin
               state_d = LAUNCH;
               error_d = 1'b0;
               cycle_d = '0;
            end
         end
         LAUNCH: begin
            busy         = 1'b1;
            layer_enable = onehot;
            layer_reset  = onehot;
            tmo_d        = '0;
            state_d      = RUN;
         end
         RUN: begin
            busy         = 1'b1;
            layer_enable = onehot;
            tmo_d        = tmo_q + 32'd1;
            // tmo_q==0 marks the first RUN cycle: a finished flag left over
            // from the previous inference may still be visible there.
            if (tmo_q != '0 && fin_act) begin
               state_d = NEXT;
            end else if (tmo_q == TMO_LAST) begin
               state_d = ERROR;
               error_d = 1'b1;
            end
         end
         NEXT: begin
            busy = 1'b1;
            if (idx_q == 2'd2) begin
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               state_d = LAUNCH;
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         ERROR: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (busy && cycle_q != '1) begin
         cycle_d = cycle_q + 32'd1;
      end
   end

   // Active-layer index and its parameter-memory base addresses.
   always_comb begin
      layer_idx = busy ? idx_q : 2'd0;
      case (layer_idx)
         2'd1:    begin weight_base = W_BASE1; bias_base = B_BASE1; end
         2'd2:    begin weight_base = W_BASE2; bias_base = B_BASE2; end
         default: begin weight_base = '0;      bias_base = '0;      end
      endcase
   end

   assign error       = error_q;
   assign cycle_count = cycle_q;

endmodule
